// File: rtl/biu_pkg.sv
// -----------------------------------------------------------------------------
// biu_pkg -- shared definitions for the multi-slave bus interface unit.
//
// Contents:
//   tgt_e          : decoded target of a CPU access (slave, status block, error)
//   STAT_OFF_*     : byte offsets of the status registers inside the status block
//   ERR_RDATA      : read data returned for a decode-error access
// -----------------------------------------------------------------------------
package biu_pkg;

  typedef enum logic [1:0] {
    SLV  = 2'd0,
    STAT = 2'd1,
    ERR  = 2'd2
  } tgt_e;

  localparam logic [3:0] STAT_OFF_ERR_CNT  = 4'h0;
  localparam logic [3:0] STAT_OFF_ERR_ADDR = 4'h4;
  localparam logic [3:0] STAT_OFF_RD_CNT   = 4'h8;
  localparam logic [3:0] STAT_OFF_WR_CNT   = 4'hC;

  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/biu_stat.sv
// -----------------------------------------------------------------------------
// biu_stat -- status register block of biu_multi.
//
// Holds the error counter, the last erroring address and, when the macro
// BIU_PERF_CNT_EN is defined, the slave read/write access counters.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   err_evt        : one decode error to record this cycle
//   err_addr       : address of that erroring access
//   clr            : write to the error-count register; clears err_cnt and
//                    last_err_addr and takes priority over err_evt
//   rd_evt, wr_evt : slave read / slave write this cycle (BIU_PERF_CNT_EN only)
//   rd_cnt, wr_cnt : free-running access counters   (BIU_PERF_CNT_EN only)
//   err_cnt        : saturating 16-bit error count
//   last_err_addr  : address captured on the most recent error
// -----------------------------------------------------------------------------
module biu_stat (
  input  logic        clk,
  input  logic        reset,
  input  logic        err_evt,
  input  logic [31:0] err_addr,
  input  logic        clr,
`ifdef BIU_PERF_CNT_EN
  input  logic        rd_evt,
  input  logic        wr_evt,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
`endif
  output logic [15:0] err_cnt,
  output logic [31:0] last_err_addr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt       <= 16'h0;
      last_err_addr <= 32'h0;
    end else if (clr) begin
      err_cnt       <= 16'h0;
      last_err_addr <= 32'h0;
    end else if (err_evt) begin
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'h1;
      end
      last_err_addr <= err_addr;
    end
  end

`ifdef BIU_PERF_CNT_EN
  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= 32'h0;
      wr_cnt <= 32'h0;
    end else begin
      if (rd_evt) rd_cnt <= rd_cnt + 32'h1;
      if (wr_evt) wr_cnt <= wr_cnt + 32'h1;
    end
  end
`endif

endmodule

// File: rtl/biu_multi.sv
// -----------------------------------------------------------------------------
// biu_multi -- CPU to NSLV-slave bus interface unit with a status block.
//
// Optional feature macro: BIU_PERF_CNT_EN adds slave read/write counters at
// status offsets 8 and C; without it those offsets read 0.
//
// The CPU port has no handshake: every clock cycle is one access. dwe != 0
// marks a write, dwe == 0 a read. Address, write data and byte enables go to
// the slaves combinationally in the access cycle; read data is returned one
// cycle later for every target (slave, status block or decode error).
//
// Parameters:
//   NSLV      : number of slave ports (1..8)
//   SEL_LSB   : lowest address bit of the slave-select field
//   STAT_BASE : base address of the 16-byte status block
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   daddr, dwdata, dwe  : CPU address, write data, byte write enables
//   drdata              : read data to the CPU (one cycle after the access)
//   daddr_o, dwdata_o   : per-slave address / write data, slot k at [32k+31:32k]
//   dwe_o               : per-slave byte enables, slot k at [4k+3:4k]
//   drdata_i            : per-slave read data, slot k at [32k+31:32k]
//   err                 : one-cycle pulse in the cycle after a decode error
// -----------------------------------------------------------------------------
module biu_multi
  import biu_pkg::*;
#(
  parameter int          NSLV      = 2,
  parameter int          SEL_LSB   = 16,
  parameter logic [31:0] STAT_BASE = 32'hFFFF_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          daddr,
  input  logic [31:0]          dwdata,
  input  logic [3:0]           dwe,
  output logic [31:0]          drdata,
  output logic [NSLV*32-1:0]   daddr_o,
  output logic [NSLV*32-1:0]   dwdata_o,
  output logic [NSLV*4-1:0]    dwe_o,
  input  logic [NSLV*32-1:0]   drdata_i,
  output logic                 err
);

  // ---------------------------------------------------------------------------
  // Address decode (combinational, current access)
  // ---------------------------------------------------------------------------
  logic [31:0] sel_field;
  logic [2:0]  slv_idx;
  tgt_e        tgt;

  assign sel_field = daddr >> SEL_LSB;
  assign slv_idx   = sel_field[2:0];

  // The status block is checked first so a slave window can never shadow it.
  always_comb begin
    tgt = ERR;
    if (daddr[31:4] == STAT_BASE[31:4]) begin
      tgt = STAT;
    end else if (sel_field < 32'(NSLV)) begin
      tgt = SLV;
    end
  end

  // ---------------------------------------------------------------------------
  // Slave request fan-out
  // ---------------------------------------------------------------------------
  assign daddr_o  = {NSLV{daddr}};
  assign dwdata_o = {NSLV{dwdata}};

  // Byte enables only reach the decoded slave, and never during reset.
  always_comb begin
    dwe_o = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (!reset && (tgt == SLV) && (slv_idx == 3'(k))) begin
        dwe_o[4*k +: 4] = dwe;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered target for the one-cycle read return
  // ---------------------------------------------------------------------------
  tgt_e        tgt_q;
  logic [2:0]  slv_q;
  logic [3:0]  soff_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q      <= SLV;
      slv_q      <= 3'd0;
      soff_q     <= 4'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      tgt_q      <= tgt;
      slv_q      <= slv_idx;
      soff_q     <= daddr[3:0];
      err_q      <= (tgt == ERR);
      err_addr_q <= daddr;
    end
  end

  assign err = err_q & ~reset;

  // ---------------------------------------------------------------------------
  // Status block
  // ---------------------------------------------------------------------------
  // Errors are recorded from the registered pulse, so a clearing write issued
  // in the cycle right after an erroring access meets that error in the same
  // update and wins.
  logic        stat_clr;
  logic [15:0] err_cnt;
  logic [31:0] last_err_addr;

  assign stat_clr = (tgt == STAT) && (daddr[3:0] == STAT_OFF_ERR_CNT) && (dwe != 4'h0);

`ifdef BIU_PERF_CNT_EN
  logic        rd_evt;
  logic        wr_evt;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  assign rd_evt = (tgt == SLV) && (dwe == 4'h0);
  assign wr_evt = (tgt == SLV) && (dwe != 4'h0);
`endif

  biu_stat u_stat (
    .clk           (clk),
    .reset         (reset),
    .err_evt       (err_q),
    .err_addr      (err_addr_q),
    .clr           (stat_clr),
`ifdef BIU_PERF_CNT_EN
    .rd_evt        (rd_evt),
    .wr_evt        (wr_evt),
    .rd_cnt        (rd_cnt),
    .wr_cnt        (wr_cnt),
`endif
    .err_cnt       (err_cnt),
    .last_err_addr (last_err_addr)
  );

  // ---------------------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------------------
  logic [31:0] slv_rdata;
  logic [31:0] stat_rdata;

  always_comb begin
    slv_rdata = 32'h0;
    for (int k = 0; k < NSLV; k++) begin
      if (slv_q == 3'(k)) begin
        slv_rdata = drdata_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    stat_rdata = 32'h0;
    case (soff_q)
      STAT_OFF_ERR_CNT:  stat_rdata = {16'h0, err_cnt};
      STAT_OFF_ERR_ADDR: stat_rdata = last_err_addr;
`ifdef BIU_PERF_CNT_EN
      STAT_OFF_RD_CNT:   stat_rdata = rd_cnt;
      STAT_OFF_WR_CNT:   stat_rdata = wr_cnt;
`endif
      default:           stat_rdata = 32'h0;
    endcase
  end

  always_comb begin
    drdata = ERR_RDATA;
    if (!reset) begin
      case (tgt_q)
        SLV:     drdata = slv_rdata;
        STAT:    drdata = stat_rdata;
        default: drdata = ERR_RDATA;
      endcase
    end
  end

endmodule

// File: tb/tb_biu_multi.sv
// -----------------------------------------------------------------------------
// tb_biu_multi -- directed scoreboard bench for biu_multi (NSLV = 3).
//
// Every driven cycle pushes one expectation record. The monitor pops a record
// in the cycle it was driven (byte enables, fan-out, reset forcing) and checks
// its read data / err pulse in the following cycle.
// Build with or without BIU_PERF_CNT_EN; the counter expectations follow.
// -----------------------------------------------------------------------------
module tb_biu_multi;

  localparam int          NSLV = 3;
  localparam logic [31:0] SB   = 32'hFFFF_0000;

`ifdef BIU_PERF_CNT_EN
  localparam logic [31:0] EXP_RD = 32'd5;
  localparam logic [31:0] EXP_WR = 32'd3;
`else
  localparam logic [31:0] EXP_RD = 32'd0;
  localparam logic [31:0] EXP_WR = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [31:0]          daddr = SB;
  logic [31:0]          dwdata = 32'h0;
  logic [3:0]           dwe = 4'h0;
  logic [31:0]          drdata;
  logic [NSLV*32-1:0]   daddr_o;
  logic [NSLV*32-1:0]   dwdata_o;
  logic [NSLV*4-1:0]    dwe_o;
  logic [NSLV*32-1:0]   drdata_i;
  logic                 err;

  // Fixed slave read data: slave 2 = CAFE_F00D, slave 1 = A000_0001, slave 0 = A000_0000
  assign drdata_i = {32'hCAFE_F00D, 32'hA000_0001, 32'hA000_0000};

  always #5 clk = ~clk;

  biu_multi #(
    .NSLV      (NSLV),
    .SEL_LSB   (16),
    .STAT_BASE (SB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .daddr_o  (daddr_o),
    .dwdata_o (dwdata_o),
    .dwe_o    (dwe_o),
    .drdata_i (drdata_i),
    .err      (err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic                rst;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [NSLV*4-1:0]   dwe_o;
    logic                chk_rd;
    logic [31:0]         rd;
    logic                err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one access per call
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic [NSLV*4-1:0] exp_dwe,
                       input logic chk, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = r;
    daddr  = a;
    dwdata = wd;
    dwe    = we;
    e.rst    = r;
    e.addr   = a;
    e.wdata  = wd;
    e.dwe_o  = exp_dwe;
    e.chk_rd = chk;
    e.rd     = exp_rd;
    e.err    = exp_err;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err);
    drive(1'b0, a, 32'h0, 4'h0, '0, 1'b1, exp_rd, exp_err);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t pend;
    bit   pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (pv) begin
        if (pend.chk_rd) cmp($sformatf("drdata@%h", pend.addr), drdata, pend.rd);
        cmp($sformatf("err@%h", pend.addr), 32'(err), 32'(pend.err));
      end
      if (exp_q.size() > 0) begin
        pend = exp_q.pop_front();
        pv   = 1'b1;
        cmp($sformatf("dwe_o@%h", pend.addr), 32'(dwe_o), 32'(pend.dwe_o));
        for (int k = 0; k < NSLV; k++) begin
          cmp($sformatf("daddr_o[%0d]", k), daddr_o[32*k +: 32], pend.addr);
          cmp($sformatf("dwdata_o[%0d]", k), dwdata_o[32*k +: 32], pend.wdata);
        end
        if (pend.rst) begin
          cmp("drdata_in_reset", drdata, 32'h0);
          cmp("err_in_reset", 32'(err), 32'h0);
        end
      end else begin
        pv = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset and reset-state status registers
    drive(1'b1, SB, 32'h0, 4'h0, '0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, SB, 32'h0, 4'h0, '0, 1'b0, 32'h0, 1'b0);
    rd(SB + 32'h0, 32'h0, 1'b0);
    rd(SB + 32'h4, 32'h0, 1'b0);
    rd(SB + 32'h8, 32'h0, 1'b0);
    rd(SB + 32'hC, 32'h0, 1'b0);

    // Slave write: only slave 1 gets the byte enables
    drive(1'b0, 32'h0001_0010, 32'h1234_5678, 4'hF, 12'h0F0, 1'b1, 32'hA000_0001, 1'b0);
    // Slave reads, one-cycle latency
    rd(32'h0002_0000, 32'hCAFE_F00D, 1'b0);
    rd(32'h0000_0004, 32'hA000_0000, 1'b0);
    rd(32'h0001_FFFC, 32'hA000_0001, 1'b0);
    rd(32'h0002_0008, 32'hCAFE_F00D, 1'b0);
    rd(32'h0000_0000, 32'hA000_0000, 1'b0);
    // Partial-byte writes to slaves 0 and 2
    drive(1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 4'h3, 12'h003, 1'b1, 32'hA000_0000, 1'b0);
    drive(1'b0, 32'h0002_FFF0, 32'h5555_AAAA, 4'h8, 12'h800, 1'b1, 32'hCAFE_F00D, 1'b0);

    // Performance counters: 5 slave reads, 3 slave writes
    rd(SB + 32'h8, EXP_RD, 1'b0);
    rd(SB + 32'hC, EXP_WR, 1'b0);
    // Writes to offsets 8 and 4 are ignored; status accesses are not counted
    drive(1'b0, SB + 32'h8, 32'hFFFF_FFFF, 4'hF, '0, 1'b1, EXP_RD, 1'b0);
    rd(SB + 32'h8, EXP_RD, 1'b0);
    drive(1'b0, SB + 32'h4, 32'h1111_1111, 4'hF, '0, 1'b1, 32'h0, 1'b0);
    rd(SB + 32'h4, 32'h0, 1'b0);

    // Decode error on a write: no byte enables, err pulse, zero read data
    drive(1'b0, 32'h0005_0000, 32'hFFFF_FFFF, 4'hF, '0, 1'b1, 32'h0, 1'b1);
    rd(SB + 32'h0, 32'h1, 1'b0);
    rd(SB + 32'h4, 32'h0005_0000, 1'b0);
    // Decode error on a read at the first slot beyond NSLV
    rd(32'h0003_0000, 32'h0, 1'b1);
    rd(SB + 32'h0, 32'h2, 1'b0);
    rd(SB + 32'h4, 32'h0003_0000, 1'b0);

    // Clear versus error: clearing write meets the recorded error, clear wins
    drive(1'b0, 32'h0100_0000, 32'h0, 4'h1, '0, 1'b1, 32'h0, 1'b1);
    drive(1'b0, SB + 32'h0, 32'h0, 4'hF, '0, 1'b1, 32'h0, 1'b0);
    rd(SB + 32'h0, 32'h0, 1'b0);
    rd(SB + 32'h4, 32'h0, 1'b0);

    // Back-to-back errors, one just above the status block
    rd(32'h1234_0000, 32'h0, 1'b1);
    rd(32'hFFFF_0010, 32'h0, 1'b1);
    rd(SB + 32'h0, 32'h2, 1'b0);
    rd(SB + 32'h4, 32'hFFFF_0010, 1'b0);
    // Plain clear
    drive(1'b0, SB + 32'h0, 32'h0, 4'h2, '0, 1'b1, 32'h0, 1'b0);
    rd(SB + 32'h4, 32'h0, 1'b0);

    // Reset mid-operation: leave an error recorded, then reset during a write
    rd(32'h0004_0000, 32'h0, 1'b1);
    rd(SB + 32'h0, 32'h1, 1'b0);
    drive(1'b0, SB, 32'h0, 4'h0, '0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h0000_0000, 32'hAAAA_5555, 4'hF, '0, 1'b0, 32'h0, 1'b0);
    rd(SB + 32'h0, 32'h0, 1'b0);
    rd(SB + 32'h4, 32'h0, 1'b0);
    rd(SB + 32'h8, 32'h0, 1'b0);
    rd(SB + 32'hC, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/biu_multi.md
BIU_MULTI -- requirements
Module: biu_multi

Interface
REQ-001 SHALL have parameter NSLV, default 2: number of slave ports, 1..8.
REQ-002 SHALL have parameter SEL_LSB, default 16: lowest address bit of the slave-select field.
REQ-003 SHALL have parameter STAT_BASE, default 32'hFFFF_0000: base address of the internal status block.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports daddr, dwdata, input, 32 each: CPU address and write data.
REQ-007 SHALL have port dwe, input, 4: CPU byte write enables.
REQ-008 SHALL have port drdata, output, 32: read data to the CPU.
REQ-009 SHALL have ports daddr_o, dwdata_o, output, NSLV*32 each: per-slave address and write data, slot k in bits [32k+31:32k].
REQ-010 SHALL have port dwe_o, output, NSLV*4: per-slave byte enables.
REQ-011 SHALL have port drdata_i, input, NSLV*32: per-slave read data.
REQ-012 SHALL have port err, output, 1: one-cycle pulse on a decode error.

Function
REQ-013 SHALL decode the target as slave k when daddr[31:SEL_LSB]==k and k<NSLV.
REQ-014 SHALL decode the status block when daddr[31:4]==STAT_BASE[31:4]; all other addresses are decode errors.
REQ-015 SHALL drive every slave with daddr and dwdata, and pass dwe only to the decoded slave (4'b0 to all others) in the same cycle, combinationally.
REQ-016 SHALL register the decoded target each cycle and mux drdata from it, giving a read latency of 1 cycle for slave and status reads alike.
REQ-017 SHALL return 32'h0 on drdata in the cycle after a decode-error access.
REQ-018 SHALL assert err for exactly one cycle after a decode-error access, with or without dwe set.
REQ-019 SHALL drop writes to decode-error addresses; no dwe_o bit asserts.
REQ-020 SHALL map the status registers as:
- STAT_BASE+0: {16'b0, err_cnt}
- STAT_BASE+4: last_err_addr
- STAT_BASE+8: rd_cnt
- STAT_BASE+C: wr_cnt
REQ-021 SHALL increment err_cnt, a 16-bit counter, on each error and saturate it at 16'hFFFF.
REQ-022 SHALL capture the erroring daddr into last_err_addr on each error.
REQ-023 SHALL clear err_cnt and last_err_addr on any write (dwe!=0) to STAT_BASE+0; if an error occurs in the same cycle, the clear wins.
REQ-024 SHALL ignore writes to status offsets 4, 8 and C.
REQ-025 SHALL count rd_cnt on slave accesses with dwe==0, and wr_cnt on slave accesses with dwe!=0; status-block accesses are not counted.
REQ-026 SHALL let rd_cnt and wr_cnt wrap modulo 2^32.

Reset
REQ-027 SHALL, while reset is high, force dwe_o to 0, err to 0, drdata to 0, all counters and last_err_addr to 0, and the registered target to slave 0.
REQ-028 SHALL abandon any access in progress when reset is asserted mid-operation; no write reaches any slave during the reset cycle.

Configuration
REQ-029 SHALL implement rd_cnt and wr_cnt only when BIU_PERF_CNT_EN is defined.
REQ-030 SHALL, without BIU_PERF_CNT_EN, have no counter flops, read offsets 8 and C as 32'h0, and leave every other behaviour unchanged.

Structure
REQ-031 SHALL place the status offsets, the error read value 32'h0 and the target-select enum (SLV, STAT, ERR) in package biu_pkg.
REQ-032 SHALL implement the status block as one sub-module, biu_stat, holding all counters and last_err_addr; decode and the read mux stay in biu_multi.

Verification
REQ-033 SHALL cover slave write: NSLV=3, write 32'h1234_5678 to 0x0001_0010 with dwe=4'hF -> only slave 1 dwe_o=4'hF; slaves 0 and 2 see 0.
REQ-034 SHALL cover slave read: read 0x0002_0000 with slave 2 driving 32'hCAFE_F00D -> drdata=32'hCAFE_F00D exactly one cycle later.
REQ-035 SHALL cover decode error: write to 0x0005_0000 -> err pulses 1 cycle, no dwe_o set, STAT+0 reads 1, STAT+4 reads 32'h0005_0000.
REQ-036 SHALL cover clear versus error: a write to STAT+0 in the same cycle as an error -> err_cnt reads 0 afterwards.
REQ-037 SHALL cover performance counters: with BIU_PERF_CNT_EN, 5 slave reads and 3 slave writes -> STAT+8=5, STAT+C=3; without the macro both read 0.
REQ-038 SHALL cover reset mid-operation: reset asserted during a write to slave 0 -> dwe_o=0 that cycle, all status registers read 0 after release.
